// File: rtl/fir_pkg.sv
// fir_pkg: width helpers and the round/saturate step shared by the FIR filter.
package fir_pkg;

  // Widest accumulator the output stage can handle after sign extension.
  localparam int MAX_W = 128;

  // Result of the output scaling step: clip flag plus the scaled value.
  typedef struct packed {
    logic             sat;
    logic [MAX_W-1:0] value;
  } round_t;

  // clog2 that never returns 0, so a 1-bit index still has a legal width.
  function automatic int clog2w(input int n);
    int r;
    if (n <= 2) begin
      r = 1;
    end else begin
      r = $clog2(n);
    end
    return r;
  endfunction

  // Accumulator width: growth of the full sum can never overflow.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2w(taps);
  endfunction

  // Round half up by 'shift' bits, then clip to a signed out_w-bit range.
  function automatic round_t sat_round(input logic [MAX_W-1:0] acc, input int shift,
                                       input int out_w);
    logic signed [MAX_W-1:0] one_s;
    logic signed [MAX_W-1:0] bias_s;
    logic signed [MAX_W-1:0] r_s;
    logic signed [MAX_W-1:0] hi_s;
    logic signed [MAX_W-1:0] lo_s;
    round_t res;
    one_s = '0;
    one_s[0] = 1'b1;
    if (shift > 0) begin
      bias_s = one_s <<< (shift - 1);
    end else begin
      bias_s = '0;
    end
    r_s  = ($signed(acc) + bias_s) >>> shift;
    hi_s = (one_s <<< (out_w - 1)) - one_s;
    lo_s = -(one_s <<< (out_w - 1));
    if (r_s > hi_s) begin
      res.sat   = 1'b1;
      res.value = hi_s;
    end else if (r_s < lo_s) begin
      res.sat   = 1'b1;
      res.value = lo_s;
    end else begin
      res.sat   = 1'b0;
      res.value = r_s;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_filter_param_tap.sv
// fir_tap: one transposed-form FIR cell (coefficient, product and partial sum).
module fir_tap #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 39
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              coef_we,
  input  logic [COEF_W-1:0] coef_data,
  input  logic [DATA_W-1:0] x_in,
  input  logic              v0,
  input  logic              v1,
  input  logic [ACC_W-1:0]  s_in,
  output logic [ACC_W-1:0]  s_out
);

  localparam int PW = DATA_W + COEF_W;

  logic [COEF_W-1:0] c_q, c_d;
  logic [PW-1:0]     p_q, p_d;
  logic [ACC_W-1:0]  s_q, s_d;
  logic signed [PW-1:0] x_ext_s;
  logic signed [PW-1:0] c_ext_s;
  logic signed [PW-1:0] prod_s;

  // Next-state for coefficient, product and partial sum; clear keeps the coefficient.
  always_comb begin
    c_d = c_q;
    p_d = p_q;
    s_d = s_q;
    x_ext_s = {{COEF_W{x_in[DATA_W-1]}}, x_in};
    c_ext_s = {{DATA_W{c_q[COEF_W-1]}}, c_q};
    prod_s  = x_ext_s * c_ext_s;
    if (coef_we) begin
      c_d = coef_data;
    end else begin
      c_d = c_q;
    end
    if (clear) begin
      p_d = '0;
      s_d = '0;
    end else begin
      if (v0) begin
        p_d = prod_s;
      end else begin
        p_d = p_q;
      end
      if (v1) begin
        s_d = s_in + {{(ACC_W-PW){p_q[PW-1]}}, p_q};
      end else begin
        s_d = s_q;
      end
    end
  end

  // Tap state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      c_q <= '0;
      p_q <= '0;
      s_q <= '0;
    end else begin
      c_q <= c_d;
      p_q <= p_d;
      s_q <= s_d;
    end
  end

  assign s_out = s_q;

endmodule

// File: rtl/fir_filter_param.sv
// fir_filter_param: pipelined transposed-form FIR with loadable coefficients
// and a rounding/saturating output stage.
module fir_filter_param
  import fir_pkg::*;
#(
  parameter int TAPS   = 100,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic                     coef_we,
  input  logic [clog2w(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic [OUT_W-1:0]         dout,
  output logic                     dout_valid,
  output logic                     sat
);

  localparam int AW    = clog2w(TAPS);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);

  logic [DATA_W-1:0] x_q, x_d;
  logic              v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic [OUT_W-1:0]  dout_q, dout_d;
  logic              sat_q, sat_d;
  logic              dout_valid_q, dout_valid_d;
  logic [ACC_W-1:0]  s_chain_s [TAPS+1];
  logic [TAPS-1:0]   tap_we_s;
  logic [MAX_W-1:0]  acc_ext_s;
  round_t            round_s;
  logic              unused_hi_s;

  // Coefficient write decode; addresses at or beyond TAPS match no tap.
  always_comb begin
    tap_we_s = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (coef_we && (coef_addr == AW'(i))) begin
        tap_we_s[i] = 1'b1;
      end else begin
        tap_we_s[i] = 1'b0;
      end
    end
  end

  // The far end of the partial-sum chain contributes nothing.
  assign s_chain_s[TAPS] = '0;

  for (genvar g = 0; g < TAPS; g++) begin : g_tap
    fir_tap #(
      .DATA_W(DATA_W),
      .COEF_W(COEF_W),
      .ACC_W (ACC_W)
    ) u_tap (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .coef_we  (tap_we_s[g]),
      .coef_data(coef_data),
      .x_in     (x_q),
      .v0       (v0_q),
      .v1       (v1_q),
      .s_in     (s_chain_s[g+1]),
      .s_out    (s_chain_s[g])
    );
  end

  // Scale the full sum (tap 0 output) down and clip it to the output range.
  always_comb begin
    acc_ext_s = {{(MAX_W-ACC_W){s_chain_s[0][ACC_W-1]}}, s_chain_s[0]};
    round_s   = sat_round(acc_ext_s, SHIFT, OUT_W);
  end

  assign unused_hi_s = ^round_s.value[MAX_W-1:OUT_W];

  // Sample capture, valid shift register and output stage; clear wins over new data.
  always_comb begin
    x_d          = x_q;
    v0_d         = 1'b0;
    v1_d         = 1'b0;
    v2_d         = 1'b0;
    dout_valid_d = 1'b0;
    dout_d       = dout_q;
    sat_d        = sat_q;
    if (clear) begin
      x_d = '0;
    end else begin
      if (din_valid) begin
        x_d = din;
      end else begin
        x_d = x_q;
      end
      v0_d         = din_valid;
      v1_d         = v0_q;
      v2_d         = v1_q;
      dout_valid_d = v2_q;
      if (v2_q) begin
        dout_d = round_s.value[OUT_W-1:0];
        sat_d  = round_s.sat;
      end else begin
        dout_d = dout_q;
        sat_d  = sat_q;
      end
    end
  end

  // Pipeline and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q          <= '0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      dout_q       <= '0;
      sat_q        <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      dout_q       <= dout_d;
      sat_q        <= sat_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign sat        = sat_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed bench: a wide unscaled instance (a) and a narrow scaled instance (b)
// share one stimulus stream.
module tb_fir_filter_param;

  localparam int TAPS = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [15:0] din;
  logic        din_valid;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;
  logic [31:0] dout_a;
  logic        dv_a, sat_a;
  logic [7:0]  dout_b;
  logic        dv_b, sat_b;

  int checks   = 0;
  int failures = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] eq[$];

  fir_filter_param #(.TAPS(TAPS), .DATA_W(16), .COEF_W(16), .OUT_W(32), .SHIFT(0)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .din(din), .din_valid(din_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .dout(dout_a), .dout_valid(dv_a), .sat(sat_a));

  fir_filter_param #(.TAPS(TAPS), .DATA_W(16), .COEF_W(16), .OUT_W(8), .SHIFT(4)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .din(din), .din_valid(din_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .dout(dout_b), .dout_valid(dv_b), .sat(sat_b));

  always #5 clk = ~clk;

  // Record every result away from the active edge.
  always @(negedge clk) begin
    if (dv_a) qa.push_back(dout_a);
    if (dv_b) qb.push_back({24'd0, dout_b});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [15:0] d);
    din = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din = 16'd0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    coef_we = 1'b1;
    coef_addr = a;
    coef_data = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input bit use_b);
    int n;
    n = use_b ? qb.size() : qa.size();
    chk({tag, "_cnt"}, 32'(n), 32'(eq.size()));
    for (int i = 0; i < eq.size(); i++) begin
      chk($sformatf("%s_%0d", tag, i), use_b ? qb[i] : qa[i], eq[i]);
    end
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; din = 16'd0; din_valid = 1'b0;
    coef_we = 1'b0; coef_addr = 3'd0; coef_data = 16'd0;
    idle(2);
    rst = 1'b1;
    chk("rst_dout", dout_a, 32'd0);
    chk("rst_dv", {31'd0, dv_a}, 32'd0);
    chk("rst_sat", {31'd0, sat_b}, 32'd0);

    // Identity with explicit latency: result appears after the third edge.
    wr(3'd0, 16'd1);
    send(16'd10);
    chk("lat_e0", {31'd0, dv_a}, 32'd0);
    tick();
    chk("lat_e1", {31'd0, dv_a}, 32'd0);
    tick();
    chk("lat_e2", {31'd0, dv_a}, 32'd0);
    tick();
    chk("lat_e3_dv", {31'd0, dv_a}, 32'd1);
    chk("lat_e3_dout", dout_a, 32'd10);
    tick();
    chk("pulse_dv", {31'd0, dv_a}, 32'd0);
    chk("hold_dout", dout_a, 32'd10);
    qa.delete();
    for (int d = 20; d <= 60; d += 10) begin
      din = 16'(d);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    idle(5);
    eq = '{32'd20, 32'd30, 32'd40, 32'd50, 32'd60};
    chk_res("ident", 1'b0);
    chk("ident_sat", {31'd0, sat_a}, 32'd0);

    // Four-tap moving sum with idle gaps between samples.
    do_clear();
    wr(3'd1, 16'd1);
    wr(3'd2, 16'd1);
    wr(3'd3, 16'd1);
    qa.delete();
    send(16'd1); idle(2);
    send(16'd2); idle(1);
    send(16'd3); idle(3);
    send(16'd4);
    send(16'd5);
    idle(5);
    eq = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd14};
    chk_res("msum", 1'b0);

    // Clear mid-ramp: sample with clear dropped, in-flight result squashed.
    qa.delete();
    send(16'd1);
    send(16'd2);
    send(16'd3);
    din = 16'd4; din_valid = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; din_valid = 1'b0; din = 16'd0;
    chk("clr_dv", {31'd0, dv_a}, 32'd0);
    chk("clr_hold", dout_a, 32'd14);
    send(16'd7);
    send(16'd8);
    idle(5);
    eq = '{32'd7, 32'd15};
    chk_res("clr", 1'b0);

    // Impulse response with c[i] = i+1.
    do_clear();
    for (int i = 0; i < TAPS; i++) wr(3'(i), 16'(i + 1));
    qa.delete();
    send(16'd1);
    repeat (8) send(16'd0);
    idle(5);
    eq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd0, 32'd0, 32'd0};
    chk_res("imp", 1'b0);

    // Live update of c[0] and out-of-range writes while streaming 5s.
    do_clear();
    for (int i = 1; i < TAPS; i++) wr(3'(i), 16'd0);
    wr(3'd0, 16'd1);
    qa.delete();
    for (int k = 0; k < 8; k++) begin
      din = 16'd5;
      din_valid = 1'b1;
      coef_we = 1'b0;
      if (k == 3) begin
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'd3;
      end
      if (k == 5) begin
        coef_we = 1'b1; coef_addr = 3'd6; coef_data = 16'd99;
      end
      if (k == 6) begin
        coef_we = 1'b1; coef_addr = 3'd7; coef_data = 16'd77;
      end
      tick();
    end
    din_valid = 1'b0; coef_we = 1'b0;
    idle(5);
    eq = '{32'd5, 32'd5, 32'd5, 32'd15, 32'd15, 32'd15, 32'd15, 32'd15};
    chk_res("live", 1'b0);

    // Rounding and saturation on the 8-bit, shift-by-4 instance.
    do_clear();
    wr(3'd0, 16'h7FFF);
    qb.delete();
    send(16'h7FFF); idle(4);
    chk("satp_b", {24'd0, dout_b}, 32'h7F);
    chk("satp_flag", {31'd0, sat_b}, 32'd1);
    chk("satp_a", dout_a, 32'h3FFF0001);       // 32767*32767
    chk("satp_a_flag", {31'd0, sat_a}, 32'd0);
    send(16'h8000); idle(4);
    chk("satn_b", {24'd0, dout_b}, 32'h80);
    chk("satn_flag", {31'd0, sat_b}, 32'd1);
    chk("satn_a", dout_a, 32'hC0008000);       // -32768*32767
    wr(3'd0, 16'd1);
    send(16'd24); idle(4);
    chk("rnd_up", {24'd0, dout_b}, 32'h02);    // 1.5 -> 2
    chk("rnd_flag", {31'd0, sat_b}, 32'd0);
    send(16'hFFE8); idle(4);
    chk("rnd_neg", {24'd0, dout_b}, 32'hFF);   // -1.5 -> -1
    eq = '{32'h7F, 32'h80, 32'h02, 32'hFF};
    chk_res("satq", 1'b1);

    // Reset mid-stream wipes results and coefficients.
    send(16'd9); send(16'd9); send(16'd9); send(16'd9);
    chk("pre_rst", dout_a, 32'd9);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mrst_dout", dout_a, 32'd0);
    chk("mrst_dv", {31'd0, dv_a}, 32'd0);
    chk("mrst_dout_b", {24'd0, dout_b}, 32'd0);
    qa.delete();
    send(16'd100);
    send(16'd200);
    idle(5);
    eq = '{32'd0, 32'd0};
    chk_res("post_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_filter_param.md
# fir_filter_param

Parametrised, pipelined transposed-form FIR filter. It succeeds the fixed 100-tap 16-bit filter and adds the following:
- generic tap count and data, coefficient and output widths
- run-time coefficient loading
- sample-valid gating
- history clear
- round-and-saturate output scaling

It sits in the DSP datapath between the sample source and downstream consumers, one sample per cycle maximum.

## Interface
- TAPS, 100, number of coefficients (≥2)
- DATA_W, 16, signed input sample width
- COEF_W, 16, signed coefficient width
- OUT_W, 32, signed output width
- SHIFT, 0, arithmetic right shift applied to accumulator before saturation (0..ACC_W-1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- clear  in  1  zero sample history and pipeline, coefficients kept
- din  in  DATA_W  signed input sample
- din_valid  in  1  din is a new sample this cycle
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  coefficient index (0 = applied to newest sample)
- coef_data  in  COEF_W  signed coefficient value
- dout  out  OUT_W  signed filtered, scaled, saturated output
- dout_valid  out  1  dout holds a new result
- sat  out  1  dout was clipped this result

## Operation
- ACC_W = DATA_W + COEF_W + clog2(TAPS); all internal sums are signed ACC_W, with no intermediate overflow.
- y[n] = Σ c[i]·x[n-i], i = 0..TAPS-1. Samples are counted only on din_valid cycles; idle cycles do not shift history.
- Stage 0: x_r <= din when din_valid.
- Stage 1: p[i] <= x_r·c[i] for all i when v0.
- Stage 2: s[i] <= s[i+1] + p[i] when v1; s[TAPS] is tied to 0. s[0] is the full sum.
- Stage 3: on v2, compute r = (s[0] + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, which is round half up. Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and register dout, sat, dout_valid.
- dout and sat hold their values between results. dout_valid is high for exactly one cycle per result.
- Coefficient write: c[coef_addr] <= coef_data at the edge. It affects products formed at the next edge onward. Sums already in the chain are not recomputed.
- coef_addr ≥ TAPS: the write is ignored.
- clear: at the edge, zero x_r, p[], s[], the valid pipeline and dout_valid. dout and sat hold. clear has priority over din_valid, so a sample presented in the same cycle is dropped.
- Coefficient write in the same cycle as clear: the write still takes effect.
- Reset (rst=0): all of the following are zeroed:
  - coefficients c[]
  - history (x_r, p[], s[])
  - valid pipeline (v0, v1, v2)
  - dout = 0, dout_valid = 0, sat = 0
- Reset mid-stream discards in-flight results. The filter outputs zeros until coefficients are reloaded.

## Timing
- Latency: din sampled at edge k with din_valid=1 produces dout_valid=1 after edge k+3.
- Throughput: one sample per cycle, with no backpressure. The consumer must accept every dout_valid.
- Valid pipeline v0→v1→v2→dout_valid is a plain shift register, so gaps in din_valid propagate unchanged.
- The first TAPS-1 results after reset or clear include zero history (start-up transient). They are flagged valid anyway.
- The critical path is one multiply, or one ACC_W adder, per stage. No adder tree.

## Structure
- Package fir_pkg provides:
  - function acc_width(DATA_W, COEF_W, TAPS)
  - function sat_round(acc, SHIFT, OUT_W) returning {sat, value}
  - localparam-friendly clog2 wrapper
- Sub-module fir_tap holds one coefficient register, one product register and one sum register, with enables v0 and v1 and the clear input. It is instantiated TAPS times via generate. The top holds x_r, the valid pipeline, coefficient write decode and the output stage.

## Test plan
- Identity: reset; write c[0]=1; stream din = 10, 20, 30, 40, 50, 60 → dout = 10…60, each 3 cycles after its input. All other results are 0 and sat=0.
- Moving sum with gaps: c[0..3]=1, insert idle cycles between din = 1, 2, 3, 4, 5 → dout = 1, 3, 6, 10, 14. dout_valid count is 5.
- Impulse response: load c[i]=i+1 for TAPS=100, din = 1 then 0 ×99 → dout sequence is 1, 2, …, 100, then 0.
- Saturation and rounding (SHIFT=4, OUT_W=8):
  - c[0]=32767, din=32767 → dout=127, sat=1.
  - c[0]=1, din=24 → dout=2 (24/16=1.5 rounds up), sat=0.
  - din=-32768 with c[0]=32767 → dout=-128, sat=1.
- Clear and reset mid-stream:
  - Stream a ramp; assert clear together with din_valid → that sample is dropped and in-flight dout_valid is squashed. The next result uses only post-clear samples, and coefficients are unchanged.
  - Pull rst low mid-stream → dout=0 and dout_valid=0 after that edge. All later results are 0 until coefficients are reloaded.
- Live coefficient update: stream din = 5 constantly with c[0]=1. Write c[0]=3 at edge j → results from samples whose product forms after edge j read 15, with no glitch values between. coef_addr=TAPS write → no change.
